// File: rtl/div_ctrl.sv
// div_ctrl: issues one DIV/DIVU from EX to an iterative divider, stalls the
// front of the pipe while it runs, and writes the quotient/remainder to LO/HI
// when the instruction advances.
// Optional feature macro: DIV_ZERO_BYPASS_EN -- a zero divisor completes
// without using the divider (LO = all ones, HI = dividend).
module div_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_div_valid,
  input  logic        ex_signed,
  input  logic [31:0] ex_a,
  input  logic [31:0] ex_b,
  input  logic        flush,
  input  logic        pipe_adv,
  output logic        div_start,
  output logic        div_annul,
  output logic        div_signed,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic [63:0] div_result,
  input  logic        div_ready,
  output logic        stall_req,
  output logic        hi_we,
  output logic        lo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata
);

  localparam int unsigned XLEN = 32;

  // Divider result layout: remainder in the upper half, quotient in the lower.
  typedef struct packed {
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quo;
  } div_res_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DONE  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            w_issue;
  logic            w_zero_byp;
  logic            w_capture;
  logic            w_write;
  div_res_t        w_res;

  logic [XLEN-1:0] r_div_a;
  logic [XLEN-1:0] r_div_b;
  logic            r_div_signed;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_rem;

  assign w_res   = div_res_t'(div_result);

  // A new division is accepted only from IDLE and only if EX is not being flushed.
  assign w_issue = (r_state == S_IDLE) && ex_div_valid && !flush;

`ifdef DIV_ZERO_BYPASS_EN
  // Zero divisor short-circuits straight to DONE with a fixed result.
  assign w_zero_byp = (ex_b == XLEN'(0));
`else
  // Zero divisor goes to the divider like any other operand.
  assign w_zero_byp = 1'b0;
`endif

  // State register; reset returns to IDLE immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic plus the capture and HI/LO write strobes.
  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_write   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_issue) begin
          w_next = w_zero_byp ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        // A flush beats a result arriving in the same cycle.
        if (flush) begin
          w_next = S_DRAIN;
        end else if (div_ready) begin
          w_next    = S_DONE;
          w_capture = 1'b1;
        end
      end
      S_DONE: begin
        if (flush) begin
          w_next = S_IDLE;
        end else if (pipe_adv) begin
          w_next  = S_IDLE;
          w_write = 1'b1;
        end
      end
      S_DRAIN: begin
        // Single abort cycle; a flush here changes nothing.
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Operand latch, held constant for the whole time the divider is busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div_a      <= '0;
      r_div_b      <= '0;
      r_div_signed <= 1'b0;
    end else if (w_issue) begin
      r_div_a      <= ex_a;
      r_div_b      <= ex_b;
      r_div_signed <= ex_signed;
    end
  end

  // Result holding register feeding the HI/LO write data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_quo <= '0;
      r_rem <= '0;
    end else if (w_capture) begin
      r_quo <= w_res.quo;
      r_rem <= w_res.rem;
    end else if (w_issue && w_zero_byp) begin
      r_quo <= '1;
      r_rem <= ex_a;
    end
  end

  // Divider handshake decoded straight from the state register.
  assign div_start  = (r_state == S_BUSY);
  assign div_annul  = (r_state == S_DRAIN);
  assign div_signed = r_div_signed;
  assign div_a      = r_div_a;
  assign div_b      = r_div_b;

  // Stall covers the issue cycle and BUSY; gated by reset so it drops at once.
  assign stall_req  = rst && (w_issue || (r_state == S_BUSY));

  // HI/LO write only in DONE when the instruction actually advances.
  assign hi_we      = w_write;
  assign lo_we      = w_write;
  assign hi_wdata   = r_rem;
  assign lo_wdata   = r_quo;

endmodule
